// File: rtl/mem_bus_responder.sv
// Data-memory bus responder: decodes each load/store to word RAM (with wait states),
// the I/O page (PIN/POUT/STAT) or an error response, and acknowledges it with one Ready pulse.
module mem_bus_responder #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          RAM_DEPTH   = 256,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = 32'h1001_0000,
  parameter logic [DATA_WIDTH-1:0] IO_BASE    = 32'hFFFF_0000,
  parameter int unsigned          WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Error,
  input  logic [7:0]            PortIn,
  output logic [DATA_WIDTH-1:0] PortOut
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] RamSpan = DATA_WIDTH'(4 * RAM_DEPTH);
  localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  typedef enum logic [1:0] {TgtRam, TgtPin, TgtPout, TgtStat} tgt_e;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  state_e                state_q;
  logic [3:0]            cnt_q;
  tgt_e                  tgt_q;
  logic                  wr_q, err_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q, error_q;
  logic [DATA_WIDTH-1:0] rdata_q, pout_q;
  logic [7:0]            sync1_q, sync2_q, prev_q;
  logic                  chg_q, chg_d;

  // Address decode of the live request, used at the accept edge
  logic [DATA_WIDTH-1:0] ram_off;
  logic                  ram_hit, pin_hit, pout_hit, stat_hit;
  tgt_e                  acc_tgt;
  logic                  acc_err;
  logic [AW-1:0]         acc_idx;

  assign ram_off  = Address - RAM_BASE;
  assign ram_hit  = (Address >= RAM_BASE) && (ram_off < RamSpan);
  assign pin_hit  = (Address == IO_BASE);
  assign pout_hit = (Address == IO_BASE + DATA_WIDTH'(4));
  assign stat_hit = (Address == IO_BASE + DATA_WIDTH'(8));
  assign acc_idx  = ram_off[AW+1:2];

  always_comb begin
    acc_tgt = TgtRam;
    if (pin_hit)       acc_tgt = TgtPin;
    else if (pout_hit) acc_tgt = TgtPout;
    else if (stat_hit) acc_tgt = TgtStat;
    acc_err = (MemRead == MemWrite) || (Address[1:0] != 2'b00) ||
              !(ram_hit || pout_hit || ((pin_hit || stat_hit) && !MemWrite));
  end

  // IO and zero-wait RAM enter RESP straight from IDLE, before the command registers load
  tgt_e                  cur_tgt;
  logic [AW-1:0]         cur_idx;
  logic                  cur_wr, cur_err;
  logic [DATA_WIDTH-1:0] rd_val, resp_data;

  always_comb begin
    cur_tgt = (state_q == StIdle) ? acc_tgt  : tgt_q;
    cur_idx = (state_q == StIdle) ? acc_idx  : idx_q;
    cur_wr  = (state_q == StIdle) ? MemWrite : wr_q;
    cur_err = (state_q == StIdle) ? acc_err  : err_q;
    unique case (cur_tgt)
      TgtRam:  rd_val = mem[cur_idx];
      TgtPin:  rd_val = {{(DATA_WIDTH-8){1'b0}}, sync2_q};
      TgtPout: rd_val = pout_q;
      TgtStat: rd_val = {{(DATA_WIDTH-1){1'b0}}, chg_q};
    endcase
    resp_data = (cur_err || cur_wr) ? '0 : rd_val;
  end

  logic resp_ok;
  assign resp_ok = (state_q == StResp) && !err_q;

  // A change seen in the same cycle as a PIN-read clear keeps the flag set
  always_comb begin
    chg_d = chg_q;
    if (resp_ok && !wr_q && tgt_q == TgtPin) chg_d = 1'b0;
    if (sync2_q != prev_q)                   chg_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      tgt_q   <= TgtRam;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      pout_q  <= '0;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      prev_q  <= 8'h00;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= PortIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      chg_q   <= chg_d;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Req) begin
            tgt_q   <= acc_tgt;
            wr_q    <= MemWrite;
            err_q   <= acc_err;
            idx_q   <= acc_idx;
            wdata_q <= WriteData;
            if (!acc_err && acc_tgt == TgtRam && WAIT_STATES != 0) begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end else begin
              state_q <= StResp;
              ready_q <= 1'b1;
              error_q <= acc_err;
              rdata_q <= resp_data;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            error_q <= err_q;
            rdata_q <= resp_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (resp_ok && wr_q && tgt_q == TgtPout) pout_q <= wdata_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM is deliberately left out of reset; a reset in RESP returns to IDLE before this edge
  always_ff @(posedge clk) begin
    if (resp_ok && wr_q && tgt_q == TgtRam) mem[idx_q] <= wdata_q;
  end

  assign Ready    = ready_q;
  assign Error    = error_q;
  assign ReadData = rdata_q;
  assign PortOut  = pout_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: expected responses are queued as commands are
// driven and compared by a monitor whenever Ready pulses.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset, Req, MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        Ready, Error;
  logic [7:0]  PortIn;

  mem_bus_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .Ready     (Ready),
    .ReadData  (ReadData),
    .Error     (Error),
    .PortIn    (PortIn),
    .PortOut   (PortOut)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    if (Ready) begin
      check_eq("ready_not_consecutive", 32'(ready_prev), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_ready", 32'(Ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq({mon_e.tag, "_err"}, 32'(Error), 32'(mon_e.err));
        if (mon_e.chk_data) check_eq({mon_e.tag, "_data"}, ReadData, mon_e.data);
      end
    end else if (Error) begin
      check_eq("error_without_ready", 32'(Error), 32'd0);
    end
    ready_prev = Ready;
  end

  task automatic push_exp(input string tag, input logic rd, input logic err,
                          input logic [31:0] data);
    exp_t e;
    e.tag      = tag;
    e.err      = err;
    e.chk_data = rd || err;
    e.data     = err ? 32'd0 : data;
    sb.push_back(e);
  endtask

  // Drives one command while idle; optionally drops Req and scrambles inputs after accept
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_data, input bit drop);
    int n;
    @(negedge clk);
    Req = 1'b1; MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
    push_exp(tag, rd, exp_err, exp_data);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        Req = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Address = 32'hFFFF_0008; WriteData = 32'h0;
      end
    end while (!Ready && n < 20);
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
    Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; PortIn = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(Ready), 32'd0);
    check_eq("rst_error", 32'(Error), 32'd0);
    check_eq("rst_rdata", ReadData, 32'd0);
    check_eq("rst_portout", PortOut, 32'd0);
    reset = 1'b0;

    txn("ram_wr", 0, 1, 32'h1001_0010, 32'hDEAD_BEEF, 3, 0, 32'h0, 0);
    txn("ram_rd", 1, 0, 32'h1001_0010, 32'h0, 3, 0, 32'hDEAD_BEEF, 0);

    txn("pout_wr", 0, 1, 32'hFFFF_0004, 32'h0000_00A5, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("portout_after_wr", PortOut, 32'h0000_00A5);
    txn("pout_rd", 1, 0, 32'hFFFF_0004, 32'h0, 1, 0, 32'h0000_00A5, 0);

    @(negedge clk);
    PortIn = 8'h3C;
    repeat (5) @(negedge clk);
    txn("stat_rd_set", 1, 0, 32'hFFFF_0008, 32'h0, 1, 0, 32'h1, 0);
    txn("pin_rd", 1, 0, 32'hFFFF_0000, 32'h0, 1, 0, 32'h3C, 0);
    txn("stat_rd_clr", 1, 0, 32'hFFFF_0008, 32'h0, 1, 0, 32'h0, 0);

    txn("err_misaligned", 1, 0, 32'h1001_0002, 32'h0, 1, 1, 32'h0, 0);
    txn("err_past_ram", 1, 0, 32'h1001_0400, 32'h0, 1, 1, 32'h0, 0);
    txn("err_rd_and_wr", 1, 1, 32'h1001_0010, 32'h1234_5678, 1, 1, 32'h0, 0);
    txn("err_pin_wr", 0, 1, 32'hFFFF_0000, 32'h0000_0055, 1, 1, 32'h0, 0);
    txn("err_no_cmd", 0, 0, 32'h1001_0010, 32'h0, 1, 1, 32'h0, 0);
    @(negedge clk);
    check_eq("portout_kept", PortOut, 32'h0000_00A5);
    txn("ram_rd_kept", 1, 0, 32'h1001_0010, 32'h0, 3, 0, 32'hDEAD_BEEF, 0);

    txn("ram_wr_drop", 0, 1, 32'h1001_0020, 32'hCAFE_F00D, 3, 0, 32'h0, 1);
    txn("ram_rd_drop", 1, 0, 32'h1001_0020, 32'h0, 3, 0, 32'hCAFE_F00D, 0);

    // Reset one cycle into a RAM write: no response, no write
    @(negedge clk);
    Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Address = 32'h1001_0010; WriteData = 32'h1111_1111;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    Req = 1'b0; MemWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_ready", 32'(Ready), 32'd0);
    end
    reset = 1'b0;
    txn("ram_rd_abort", 1, 0, 32'h1001_0010, 32'h0, 3, 0, 32'hDEAD_BEEF, 0);

    // Back-to-back reads with Req held
    @(negedge clk);
    Req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h1001_0020;
    push_exp("b2b_first", 1, 0, 32'hCAFE_F00D);
    push_exp("b2b_second", 1, 0, 32'hCAFE_F00D);
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!Ready && n < 20);
    check_eq("b2b_first_latency", 32'(n), 32'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!Ready && n < 20);
    check_eq("b2b_ready_gap", 32'(n), 32'd4);
    Req = 1'b0; MemRead = 1'b0;

    repeat (6) @(negedge clk);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the processor's data-memory bus: the processor (MEM stage) initiates loads and stores; this block accepts them, services them and acknowledges each one.
- Decodes each address to one of three targets:
  - word RAM with a configurable number of wait states;
  - a memory-mapped I/O page holding the 8-bit input port, the 32-bit output port and a status register;
  - error for anything else.
- Sits between the pipeline's MEM stage (initiator) and the board pins (PortIn/PortOut).

Parameters:
- DATA_WIDTH, 32, data and address width.
- RAM_DEPTH, 256, RAM size in 32-bit words.
- RAM_BASE, 32'h1001_0000, byte address of RAM word 0.
- IO_BASE, 32'hFFFF_0000, byte address of the I/O page.
- WAIT_STATES, 2, extra cycles before a RAM response (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Req  in  1  initiator has a valid command.
- MemRead  in  1  read command.
- MemWrite  in  1  write command.
- Address  in  32  byte address.
- WriteData  in  32  store data.
- Ready  out  1  one-cycle response strobe.
- ReadData  out  32  load data, valid when Ready=1.
- Error  out  1  response is an error; valid when Ready=1.
- PortIn  in  8  asynchronous external input.
- PortOut  out  32  output port register.

Behaviour:
- Reset (async, active-high):
  - state IDLE, wait counter 0.
  - Ready=0, Error=0, ReadData=0, PortOut=0.
  - Synchroniser flops 0, status CHG=0.
  - RAM contents are not reset.
- FSM states IDLE, WAIT, RESP.
  - IDLE: Req=1 is sampled at edge T. Address, WriteData, MemRead and MemWrite are latched; the command is committed from this edge onward.
  - IDLE -> WAIT when target is RAM, WAIT_STATES>0 and the command is legal; counter loaded with WAIT_STATES-1.
  - IDLE -> RESP for I/O, error, or RAM with WAIT_STATES=0.
  - WAIT: counter decrements each cycle; -> RESP when counter=0.
  - RESP: Ready=1 for exactly one cycle, then -> IDLE.
  - A new Req is accepted no earlier than the cycle after Ready.
- Latency from the accept edge T to Ready high:
  - RAM: WAIT_STATES+1 cycles.
  - I/O and error: 1 cycle.
- Handshake:
  - Initiator holds Req and the command until Ready.
  - Changes to the inputs after accept are ignored.
  - Req dropped after accept: the transaction still completes and Ready still pulses.
- Legality checks, evaluated at accept:
  - Error=1 if MemRead=MemWrite=1, Address[1:0]!=0, or the address hits neither RAM nor a defined I/O register.
  - An error response writes nothing and returns ReadData=0.
  - Req with MemRead=MemWrite=0: Error=1.
- RAM decode:
  - Hit when RAM_BASE <= Address < RAM_BASE+4*RAM_DEPTH.
  - Word index = (Address-RAM_BASE)>>2, truncated to clog2(RAM_DEPTH) bits.
  - Write is performed on the RESP cycle edge. Read data is registered into ReadData at entry to RESP.
- I/O registers:
  - IO_BASE+0 PIN (read-only): {24'b0, PortIn_sync}. A write to it is an error.
  - IO_BASE+4 POUT (read/write): PortOut updates on the RESP edge. Reads return the current PortOut.
  - IO_BASE+8 STAT (read-only): {31'b0, CHG}. A write to it is an error.
- PortIn synchroniser and change flag:
  - Two-flop synchroniser; PortIn_sync lags PortIn by 2 edges.
  - CHG sets when PortIn_sync differs from its value one cycle earlier.
  - CHG clears on the RESP edge of a PIN read.
  - Set and clear in the same cycle: set wins.
- ReadData holds its last value until the next response. Error is 0 whenever Ready=0.
- Reset during WAIT or RESP: the transaction is aborted, no RAM or PortOut write occurs, and Ready is not issued.

Test Plan:
- Default parameters: write 32'hDEAD_BEEF to 32'h1001_0010, then read the same address → Ready 3 cycles after each accept, Error=0, ReadData=32'hDEAD_BEEF.
- Write 32'h0000_00A5 to IO_BASE+4 → Ready 1 cycle after accept, PortOut=32'hA5 the cycle after Ready. Read IO_BASE+4 → ReadData=32'hA5.
- PortIn changes 8'h00 → 8'h3C:
  - PIN read more than 2 cycles later → ReadData=32'h3C.
  - STAT read before the PIN read → 32'h1.
  - STAT read after the PIN read → 32'h0.
- Error cases, each → Ready after 1 cycle, Error=1, ReadData=0, no state change:
  - read 32'h1001_0002 (misaligned);
  - read 32'h1001_0400 (just past the RAM);
  - MemRead=MemWrite=1;
  - write to IO_BASE+0.
- Accept a RAM write, drop Req the next cycle → Ready still arrives at T+3 and the data is written. Separately, assert reset at T+1 of a RAM write → no Ready, and a later read of that word returns the prior contents.
- Back-to-back: Req held high continuously for two RAM reads → second accept on the cycle after the first Ready, Ready pulses spaced 4 cycles apart, never two consecutive Ready cycles.
